// File: rtl/tlb_entry_array.sv
// Fully-associative TLB storage: one write port (TLBWI), one read port (TLBR),
// and two independent combinational lookup ports (fetch s0, memory/TLBP s1).
module tlb_entry_array #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  // fetch lookup
  input  logic [18:0]      s0_vpn2,
  input  logic             s0_odd_page,
  input  logic [7:0]       s0_asid,
  output logic             s0_found,
  output logic [IDX_W-1:0] s0_index,
  output logic [19:0]      s0_pfn,
  output logic [2:0]       s0_c,
  output logic             s0_d,
  output logic             s0_v,
  // memory / TLBP lookup
  input  logic [18:0]      s1_vpn2,
  input  logic             s1_odd_page,
  input  logic [7:0]       s1_asid,
  output logic             s1_found,
  output logic [IDX_W-1:0] s1_index,
  output logic [19:0]      s1_pfn,
  output logic [2:0]       s1_c,
  output logic             s1_d,
  output logic             s1_v,
  // write port
  input  logic             we,
  input  logic [IDX_W-1:0] w_index,
  input  logic [18:0]      w_vpn2,
  input  logic [7:0]       w_asid,
  input  logic             w_g,
  input  logic [19:0]      w_pfn0,
  input  logic [2:0]       w_c0,
  input  logic             w_d0,
  input  logic             w_v0,
  input  logic [19:0]      w_pfn1,
  input  logic [2:0]       w_c1,
  input  logic             w_d1,
  input  logic             w_v1,
  // read port
  input  logic [IDX_W-1:0] r_index,
  output logic [18:0]      r_vpn2,
  output logic [7:0]       r_asid,
  output logic             r_g,
  output logic [19:0]      r_pfn0,
  output logic [2:0]       r_c0,
  output logic             r_d0,
  output logic             r_v0,
  output logic [19:0]      r_pfn1,
  output logic [2:0]       r_c1,
  output logic             r_d1,
  output logic             r_v1
);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } entry_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
    logic [19:0]      pfn;
    logic [2:0]       c;
    logic             d;
    logic             v;
  } lookup_t;

  entry_t tlb [TLBNUM];
  entry_t w_entry;

  assign w_entry = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                     pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                     pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};

  // NOTE: this storage array is reset on purpose: software relies on a
  // known all-zero TLB after reset, so it cannot map onto a plain RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) begin
        // NOTE: non-blocking so every reader sees pre-edge contents this cycle.
        tlb[i] <= '0;
      end
    end else if (we) begin
      tlb[w_index] <= w_entry;
    end
  end

  // Walk from the top so the lowest matching index is the last to win.
  function automatic lookup_t lookup(input entry_t tab [TLBNUM],
                                     input logic [18:0] vpn2,
                                     input logic odd,
                                     input logic [7:0] asid);
    // NOTE: result is fully defaulted before the loop, so no path leaves it
    // unassigned and no latch is inferred in the callers' combinational logic.
    lookup_t res;
    res = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (tab[i].vpn2 == vpn2 && (tab[i].g || tab[i].asid == asid)) begin
        res.found = 1'b1;
        res.index = IDX_W'(i);
        res.pfn   = odd ? tab[i].pfn1 : tab[i].pfn0;
        res.c     = odd ? tab[i].c1   : tab[i].c0;
        res.d     = odd ? tab[i].d1   : tab[i].d0;
        res.v     = odd ? tab[i].v1   : tab[i].v0;
      end
    end
    return res;
  endfunction

  lookup_t s0_res, s1_res;

  assign s0_res = lookup(tlb, s0_vpn2, s0_odd_page, s0_asid);
  assign s1_res = lookup(tlb, s1_vpn2, s1_odd_page, s1_asid);

  assign s0_found = s0_res.found;
  assign s0_index = s0_res.index;
  assign s0_pfn   = s0_res.pfn;
  assign s0_c     = s0_res.c;
  assign s0_d     = s0_res.d;
  assign s0_v     = s0_res.v;

  assign s1_found = s1_res.found;
  assign s1_index = s1_res.index;
  assign s1_pfn   = s1_res.pfn;
  assign s1_c     = s1_res.c;
  assign s1_d     = s1_res.d;
  assign s1_v     = s1_res.v;

  // Read port shows stored state only; no write bypass.
  assign r_vpn2 = tlb[r_index].vpn2;
  assign r_asid = tlb[r_index].asid;
  assign r_g    = tlb[r_index].g;
  assign r_pfn0 = tlb[r_index].pfn0;
  assign r_c0   = tlb[r_index].c0;
  assign r_d0   = tlb[r_index].d0;
  assign r_v0   = tlb[r_index].v0;
  assign r_pfn1 = tlb[r_index].pfn1;
  assign r_c1   = tlb[r_index].c1;
  assign r_d1   = tlb[r_index].d1;
  assign r_v1   = tlb[r_index].v1;

endmodule

// File: tb/tb_tlb_entry_array.sv
// Directed bench for tlb_entry_array: reset clearing, write/read timing,
// lookup with ASID/global matching, page select, priority and write-cycle hazards.
`timescale 1ns/1ps
module tb_tlb_entry_array;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [18:0] s0_vpn2 = '0, s1_vpn2 = '0;
  logic        s0_odd_page = 1'b0, s1_odd_page = 1'b0;
  logic [7:0]  s0_asid = '0, s1_asid = '0;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic        s0_d, s0_v, s1_d, s1_v;
  logic        we = 1'b0;
  logic [3:0]  w_index = '0;
  logic [18:0] w_vpn2 = '0;
  logic [7:0]  w_asid = '0;
  logic        w_g = 1'b0;
  logic [19:0] w_pfn0 = '0, w_pfn1 = '0;
  logic [2:0]  w_c0 = '0, w_c1 = '0;
  logic        w_d0 = 1'b0, w_v0 = 1'b0, w_d1 = 1'b0, w_v1 = 1'b0;
  logic [3:0]  r_index = '0;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0]  r_c0, r_c1;
  logic        r_d0, r_v0, r_d1, r_v1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tlb_entry_array #(.TLBNUM(16), .IDX_W(4)) dut (
    .clk(clk), .reset(reset),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
  );

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_write(input logic [3:0] idx, input logic [18:0] vpn2,
                             input logic [7:0] asid, input logic g,
                             input logic [19:0] pfn0, input logic [2:0] c0,
                             input logic d0, input logic v0,
                             input logic [19:0] pfn1, input logic [2:0] c1,
                             input logic d1, input logic v1);
    w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
    w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
    we = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  initial begin
    // power-on reset
    #1 reset = 1'b1;
    #2;
    s0_vpn2 = 19'h0; s0_asid = 8'h00; s0_odd_page = 1'b0;
    #1;
    check("por_s0_found", s0_found, 1);
    check("por_s0_index", s0_index, 0);
    check("por_s0_v",     s0_v, 0);
    check("por_r_all",    {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
                           r_pfn1, r_c1, r_d1, r_v1}, 0);
    reset = 1'b0;
    tick();

    // fill all entries, then reset mid-cycle
    for (int i = 0; i < 16; i++) begin
      drive_write(4'(i), 19'(i + 1), 8'h00, 1'b0, 20'(i + 'h100), 3'd2, 1'b1, 1'b1,
                  20'(i + 'h200), 3'd1, 1'b1, 1'b1);
      tick();
    end
    r_index = 4'd4;
    #1;
    check("fill_r4_vpn2", r_vpn2, 19'h5);
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r_index = 4'(i);
      #0.1;
      check($sformatf("rst_r_all_%0d", i),
            {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
             r_pfn1, r_c1, r_d1, r_v1}, 0);
    end
    s0_vpn2 = 19'h1; s0_asid = 8'h00;
    #0.1;
    check("rst_s0_found", s0_found, 0);
    check("rst_s0_index", s0_index, 0);
    check("rst_s0_pfn",   s0_pfn, 0);
    tick();

    // write entry 3; read shows old contents until the edge
    r_index = 4'd3;
    drive_write(4'd3, 19'h12345, 8'h05, 1'b0, 20'hABCDE, 3'd3, 1'b1, 1'b1,
                20'h11111, 3'd0, 1'b0, 1'b0);
    #1;
    check("wcyc_r3_vpn2", r_vpn2, 0);
    check("wcyc_r3_pfn0", r_pfn0, 0);
    tick();
    check("post_r3_vpn2", r_vpn2, 19'h12345);
    check("post_r3_asid", r_asid, 8'h05);
    check("post_r3_g",    r_g, 0);
    check("post_r3_pfn0", r_pfn0, 20'hABCDE);
    check("post_r3_c0",   r_c0, 3);
    check("post_r3_d0v0", {r_d0, r_v0}, 2'b11);
    check("post_r3_pfn1", r_pfn1, 20'h11111);
    check("post_r3_v1",   r_v1, 0);

    // s1 lookups against entry 3
    s1_vpn2 = 19'h12345; s1_asid = 8'h05; s1_odd_page = 1'b0;
    #1;
    check("s1_even_found", s1_found, 1);
    check("s1_even_index", s1_index, 3);
    check("s1_even_pfn",   s1_pfn, 20'hABCDE);
    check("s1_even_c",     s1_c, 3);
    check("s1_even_dv",    {s1_d, s1_v}, 2'b11);
    s1_odd_page = 1'b1;
    #1;
    check("s1_odd_pfn", s1_pfn, 20'h11111);
    check("s1_odd_v",   s1_v, 0);
    s1_odd_page = 1'b0; s1_asid = 8'h06;
    #1;
    check("s1_asid_miss", {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}, 0);

    // global entry 7 hit from both ports with an unrelated ASID
    drive_write(4'd7, 19'h00400, 8'h01, 1'b1, 20'h07070, 3'd0, 1'b0, 1'b1,
                20'h0, 3'd0, 1'b0, 1'b0);
    tick();
    s0_vpn2 = 19'h00400; s0_asid = 8'hFF; s0_odd_page = 1'b0;
    s1_vpn2 = 19'h00400; s1_asid = 8'hFF; s1_odd_page = 1'b0;
    #1;
    check("g_s0_found", s0_found, 1);
    check("g_s0_index", s0_index, 7);
    check("g_s0_pfn",   s0_pfn, 20'h07070);
    check("g_s1_found", s1_found, 1);
    check("g_s1_index", s1_index, 7);

    // duplicate VPN2 in entries 2 and 9: lowest index wins
    drive_write(4'd2, 19'h7FFFF, 8'h00, 1'b1, 20'h22222, 3'd0, 1'b0, 1'b1,
                20'h0, 3'd0, 1'b0, 1'b0);
    tick();
    drive_write(4'd9, 19'h7FFFF, 8'h00, 1'b1, 20'h99999, 3'd0, 1'b0, 1'b1,
                20'h0, 3'd0, 1'b0, 1'b0);
    tick();
    s0_vpn2 = 19'h7FFFF; s0_asid = 8'h33;
    #1;
    check("dup_index", s0_index, 2);
    check("dup_pfn",   s0_pfn, 20'h22222);

    // overwrite entry 5 while s0 searches its old VPN2
    drive_write(4'd5, 19'h00055, 8'h00, 1'b0, 20'h55555, 3'd0, 1'b0, 1'b1,
                20'h0, 3'd0, 1'b0, 1'b0);
    tick();
    s0_vpn2 = 19'h00055; s0_asid = 8'h00;
    drive_write(4'd5, 19'h00066, 8'h00, 1'b0, 20'h66666, 3'd0, 1'b0, 1'b1,
                20'h0, 3'd0, 1'b0, 1'b0);
    #1;
    check("wcyc_s0_found", s0_found, 1);
    check("wcyc_s0_index", s0_index, 5);
    check("wcyc_s0_pfn",   s0_pfn, 20'h55555);
    tick();
    check("post_old_found", s0_found, 0);
    s0_vpn2 = 19'h00066;
    #1;
    check("post_new_index", {s0_found, s0_index}, {1'b1, 4'd5});
    check("post_new_pfn",   s0_pfn, 20'h66666);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
